joy_db9_serial_reader: RTL

// - Board-side master for the DB9 joystick shift-register chain (parallel-in/serial-out, 74HC165 type).
// - Drives JOY_LOAD and JOY_CLK, and deserialises JOY_DATA into two active-high joystick words.
// - Replaces the pass-through of the middleboard XCLK/XLOAD/XDATA lines on boards that have no

---
 rtl/joy_db9_pkg.sv | 29 ++
 rtl/joy_db9_if.sv | 23 ++
 rtl/joy_db9_tick_gen.sv | 34 +++
 rtl/joy_db9_serial_reader.sv | 134 +++++++++++++
 4 files changed

// File: rtl/joy_db9_pkg.sv
// Shared types and constants for the DB9 joystick shift-register reader.
// Bit indices name the buttons inside one active-high joystick word.
package joy_db9_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        CLKLO,
        CLKHI,
        DONE
    } state_t;

    localparam int unsigned JOY_W = 12;

    localparam int unsigned UP    = 0;
    localparam int unsigned DOWN  = 1;
    localparam int unsigned LEFT  = 2;
    localparam int unsigned RIGHT = 3;
    localparam int unsigned B1    = 4;
    localparam int unsigned B2    = 5;
    localparam int unsigned B3    = 6;
    localparam int unsigned B4    = 7;
    localparam int unsigned START = 8;
    localparam int unsigned SEL   = 9;
    localparam int unsigned MODE  = 10;
    localparam int unsigned X     = 11;

endpackage

// File: rtl/joy_db9_if.sv
// Joystick chain lines plus the decoded joystick words seen by the guest core.
// master = the reader driving the chain, slave = the chain/core side.
interface joy_db9_if #(
    parameter int unsigned NBITS = 24
);
    logic               enable;
    logic               JOY_CLK;
    logic               JOY_LOAD;
    logic               JOY_DATA;
    logic [NBITS/2-1:0] joy1;
    logic [NBITS/2-1:0] joy2;
    logic               frame_valid;

    modport master (
        input  enable, JOY_DATA,
        output JOY_CLK, JOY_LOAD, joy1, joy2, frame_valid
    );

    modport slave (
        output enable, JOY_DATA,
        input  JOY_CLK, JOY_LOAD, joy1, joy2, frame_valid
    );
endinterface

// File: rtl/joy_db9_tick_gen.sv
// Prescaler producing a one-cycle tick every CLK_DIV system cycles.
// hold freezes the count for a cycle so inserted cycles do not shorten the next tick.
module joy_db9_tick_gen
    import joy_db9_pkg::*;
#(
    parameter int unsigned CLK_DIV = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hold,
    output logic tick
);
    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == CntLast);
        cnt_d = cnt_q;
        if (!hold) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/joy_db9_serial_reader.sv
// Board-side master for a 74HC165-style DB9 joystick chain: loads, clocks and
// deserialises the chain into two active-high joystick words once per poll period.
module joy_db9_serial_reader
    import joy_db9_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 50,
    parameter int unsigned NBITS      = 24,
    parameter int unsigned POLL_TICKS = 1000
) (
    input  logic      CLOCK_50,
    input  logic      RESET_N,
    joy_db9_if.master bus
);
    localparam int unsigned Half  = NBITS / 2;
    localparam int unsigned BitW  = $clog2(NBITS);
    localparam int unsigned PollW = $clog2(POLL_TICKS + 1);
    localparam logic [BitW-1:0]  LastBit  = BitW'(NBITS - 1);
    localparam logic [PollW-1:0] PollLast = PollW'(POLL_TICKS - 1);
    localparam logic [PollW-1:0] PollTerm = PollW'(POLL_TICKS);

    state_t             state_q, state_d;
    logic [BitW-1:0]    bitcnt_q, bitcnt_d;
    logic [PollW-1:0]   poll_q, poll_d;
    logic [NBITS-1:0]   frame_q, frame_d;
    logic [NBITS-1:0]   shifted;
    logic [1:0]         sync_q;
    logic               clk_q, load_q, valid_q;
    logic [Half-1:0]    joy1_q, joy2_q;
    logic               tick;

    // The DONE cycle is extra to the tick grid, so the prescaler pauses there.
    joy_db9_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk   (CLOCK_50),
        .rst_n (RESET_N),
        .hold  (state_q == DONE),
        .tick  (tick)
    );

    assign shifted = {frame_q[NBITS-2:0], sync_q[1]};

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        poll_d   = poll_q;
        frame_d  = frame_q;
        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    if (poll_q >= PollLast) begin
                        poll_d = PollTerm;
                        if (bus.enable) begin
                            state_d = LOAD;
                        end
                    end else begin
                        poll_d = poll_q + 1'b1;
                    end
                end
            end
            LOAD: begin
                if (tick) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (tick) begin
                    frame_d  = shifted;
                    bitcnt_d = BitW'(1);
                    state_d  = CLKLO;
                end
            end
            CLKLO: begin
                if (tick) begin
                    state_d = CLKHI;
                end
            end
            CLKHI: begin
                if (tick) begin
                    frame_d = shifted;
                    if (bitcnt_q == LastBit) begin
                        state_d = DONE;
                    end else begin
                        bitcnt_d = bitcnt_q + 1'b1;
                        state_d  = CLKLO;
                    end
                end
            end
            DONE: begin
                state_d  = IDLE;
                poll_d   = '0;
                bitcnt_d = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            poll_q   <= '0;
            frame_q  <= '0;
            sync_q   <= '0;
            clk_q    <= 1'b1;
            load_q   <= 1'b1;
            valid_q  <= 1'b0;
            joy1_q   <= '0;
            joy2_q   <= '0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            poll_q   <= poll_d;
            frame_q  <= frame_d;
            sync_q   <= {sync_q[0], bus.JOY_DATA};
            // Lines follow the next state so they change exactly at the state boundary.
            clk_q    <= (state_d != CLKLO);
            load_q   <= (state_d != LOAD);
            valid_q  <= (state_d == DONE);
            if (state_d == DONE) begin
                joy1_q <= ~frame_d[NBITS-1:Half];
                joy2_q <= ~frame_d[Half-1:0];
            end
        end
    end

    assign bus.JOY_CLK     = clk_q;
    assign bus.JOY_LOAD    = load_q;
    assign bus.joy1        = joy1_q;
    assign bus.joy2        = joy2_q;
    assign bus.frame_valid = valid_q;
endmodule
